// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer for the 5-stage CPU: decides handler entry and
// eret return from the ID stage and drives flushes and the PC redirect in the same cycle.
module exception_ctrl #(
  parameter int          IRQ_W      = 4,
  parameter logic [31:0] HANDLER_PC = 32'h8000_0004,
  parameter logic [31:0] EXC_PC     = 32'h8000_0008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_W-1:0] irq,
  input  logic             irq_mask_wr,
  input  logic [IRQ_W-1:0] irq_mask_data,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic             id_undef,
  input  logic             id_eret,
  input  logic             hazard_stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic [IRQ_W-1:0] irq_ack,
  output logic [31:0]      epc,
  output logic [3:0]       cause,
  output logic             kernel,
  output logic             double_fault,
  output logic [15:0]      exc_count
);

  typedef enum logic [1:0] {S_USER, S_KERNEL, S_EXIT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_epc;
  logic [3:0]       r_cause;
  logic [IRQ_W-1:0] r_mask;
  logic             r_double_fault;
  logic [15:0]      r_exc_count;

  logic             w_adv;
  logic [IRQ_W-1:0] w_pend;
  logic [IRQ_W-1:0] w_lowest;
  logic [2:0]       w_idx;
  logic             w_take_undef;
  logic             w_take_irq;
  logic             w_take;
  logic             w_ret;
  logic             w_dfault;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_adv    = id_valid & ~hazard_stall;
  assign w_pend   = irq & r_mask;
  // Isolate the lowest set bit so the acknowledge is one-hot.
  assign w_lowest = w_pend & (~w_pend + IRQ_W'(1));

  always_comb begin
    w_idx = 3'd0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (w_pend[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_take_undef = 1'b0;
    w_take_irq   = 1'b0;
    w_ret        = 1'b0;
    w_dfault     = 1'b0;
    case (r_state)
      S_USER: begin
        if (w_adv && id_undef) begin
          w_take_undef = 1'b1;
          w_next       = S_KERNEL;
        end else if (w_adv && (|w_pend)) begin
          w_take_irq = 1'b1;
          w_next     = S_KERNEL;
        end
      end
      S_KERNEL: begin
        w_dfault = w_adv & id_undef;
        if (w_adv && id_eret) begin
          w_ret  = 1'b1;
          w_next = S_EXIT;
        end
      end
      S_EXIT: begin
        // Guard state: one user instruction must leave ID before interrupts reopen.
        if (w_adv && id_undef) begin
          w_take_undef = 1'b1;
          w_next       = S_KERNEL;
        end else if (w_adv) begin
          w_next = S_USER;
        end
      end
      default: w_next = S_USER;
    endcase
  end

  assign w_take = w_take_undef | w_take_irq;

  always_comb begin
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 32'h0;
    irq_ack     = '0;
    // Decision outputs are held quiet while reset is asserted.
    if (reset) begin
      flush_if_id = w_take | w_ret;
      flush_id_ex = w_take | w_ret;
      pc_redirect = w_take | w_ret;
      if (w_take_undef)    redirect_pc = EXC_PC;
      else if (w_take_irq) redirect_pc = HANDLER_PC;
      else if (w_ret)      redirect_pc = r_epc;
      if (w_take_irq) irq_ack = w_lowest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_USER;
      r_epc          <= 32'h0;
      r_cause        <= 4'h0;
      r_mask         <= '0;
      r_double_fault <= 1'b0;
      r_exc_count    <= 16'h0;
    end else begin
      r_state <= w_next;
      if (irq_mask_wr) r_mask <= irq_mask_data;
      // Undefined instruction returns past itself; an interrupted one re-executes.
      if (w_take_undef) begin
        r_epc   <= id_pc + 32'd4;
        r_cause <= 4'b1000;
      end else if (w_take_irq) begin
        r_epc   <= id_pc;
        r_cause <= {1'b0, w_idx};
      end
      if (w_take)   r_exc_count    <= sat_inc(r_exc_count);
      if (w_dfault) r_double_fault <= 1'b1;
    end
  end

  assign epc          = r_epc;
  assign cause        = r_cause;
  assign kernel       = (r_state == S_KERNEL);
  assign double_fault = r_double_fault;
  assign exc_count    = r_exc_count;

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Exception/interrupt sequencer for the 5-stage pipelined CPU.
- Watches the ID stage and decides when to divert the pipeline to the kernel handler and when to return from it.
- Drives the IF/ID and ID/EX flushes and the PC redirect, and holds EPC, cause, the interrupt mask and the kernel-mode bit.
- Sits beside the hazard unit. Its redirect has priority over branch/jump/jr PC selection.

Parameters:
- IRQ_W, 4: number of interrupt lines, legal range 1..8.
- HANDLER_PC, 32'h8000_0004: interrupt entry address.
- EXC_PC, 32'h8000_0008: undefined-instruction entry address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- irq  in  IRQ_W  level-sensitive interrupt requests.
- irq_mask_wr  in  1  write enable for the mask register.
- irq_mask_data  in  IRQ_W  new mask value; 1 = line enabled.
- id_valid  in  1  ID stage holds a real instruction, not a bubble.
- id_pc  in  32  address of the ID-stage instruction.
- id_undef  in  1  ID-stage opcode/funct is undefined.
- id_eret  in  1  ID-stage instruction is eret.
- hazard_stall  in  1  load-use stall is active this cycle.
- flush_if_id  out  1  clear IF/ID at the next edge.
- flush_id_ex  out  1  load a bubble into ID/EX at the next edge.
- pc_redirect  out  1  override the PC source at the next edge.
- redirect_pc  out  32  PC value to load when pc_redirect=1.
- irq_ack  out  IRQ_W  one-hot, one-cycle acknowledge of the taken line.
- epc  out  32  saved return address.
- cause  out  4  4'b1000 = undefined instruction; {1'b0, idx[2:0]} = interrupt line idx.
- kernel  out  1  1 while in KERNEL state.
- double_fault  out  1  sticky flag: undefined instruction seen in KERNEL.
- exc_count  out  16  saturating count of taken exceptions.

Behaviour:
- Reset (reset=0, asynchronous) clears all registered state:
  - state=USER; epc, cause, mask, double_fault, exc_count = 0.
  - All combinational outputs are 0 while reset is asserted.
- Qualifier: adv = id_valid & ~hazard_stall. Nothing is taken while the hazard unit stalls; the stalled instruction is re-evaluated the following cycle.
- pend = irq & mask. idx = lowest set bit of pend.
- Combinational outputs, same cycle as the decision, so there are zero added cycles of latency:
  - On a take or return: flush_if_id = flush_id_ex = pc_redirect = 1.
  - redirect_pc = EXC_PC on an undefined-instruction take, HANDLER_PC on an interrupt take, epc on a return. redirect_pc = 0 otherwise.
- States:
  - USER:
    - adv & id_undef → take exception. On the edge: epc ← id_pc+4, cause ← 8.
    - Else adv & |pend → take interrupt. On the edge: epc ← id_pc so the flushed instruction re-executes, cause ← idx, irq_ack[idx]=1 for this cycle.
    - Any take: exc_count += 1, saturating at 16'hFFFF; next state = KERNEL.
    - Undefined instruction has priority over an interrupt in the same cycle.
  - KERNEL:
    - kernel=1; interrupts are ignored.
    - adv & id_undef → double_fault ← 1. No redirect; the instruction proceeds.
    - adv & id_eret → return. Next state = EXIT.
  - EXIT, guard state (kernel=0):
    - Interrupts are not accepted.
    - id_undef is handled as in USER.
    - Moves to USER on the first edge with adv=1 and no take, i.e. at least one user instruction retires from ID before the next interrupt can be taken.
- Mask register:
  - Loads irq_mask_data on any edge with irq_mask_wr=1, in any state.
  - A take in the same cycle uses the old mask.
- epc/cause are only overwritten by a take. They are stable throughout KERNEL.
- Reset asserted mid-KERNEL returns the block to USER with kernel=0; no return redirect is issued.
- id_eret seen in USER/EXIT has no effect on this block.

Test Plan:
1. After reset release, mask=0, irq=4'b0010, 10 adv cycles → no flush, irq_ack=0, kernel=0, exc_count=0.
2. Write mask=4'b1111; irq=4'b0110, id_pc=0x0040_0010, adv → same cycle pc_redirect=1, redirect_pc=0x8000_0004, irq_ack=4'b0010, both flushes=1. Next cycle: epc=0x0040_0010, cause=1, kernel=1, exc_count=1.
3. In USER with mask=4'b0001 and irq[0]=1: id_undef=1, id_pc=0x0040_0020 → redirect_pc=0x8000_0008, epc=0x0040_0024, cause=8, irq_ack=0.
4. In KERNEL with irq=4'b1111: no take. Then id_eret & adv → redirect_pc=epc, flushes=1, kernel=0 next cycle. With irq still high: no take in EXIT until one adv cycle has passed; the take occurs on the following adv cycle.
5. irq pending with hazard_stall=1 for 3 cycles → no flush during the stall; the take occurs in the first cycle with stall=0.
6. In KERNEL, pull reset low asynchronously mid-cycle → kernel, epc, cause, mask = 0 immediately; after release a masked-off irq is not taken. Also force exc_count to 16'hFFFF and take once more → it stays at 16'hFFFF.
